prbs_gen_multi: RTL and testbench

Parametrised parallel PRBS generator with a runtime-selectable polynomial (PRBS7/15/23/31), seed load, enable, output inversion, single-bit error injection and an all-zero lock-up guard. It emits W fresh sequence bits per `clk160` cycle to the transceiver transmit data path. It supersedes the fixed 128-bit rotating PRBS7 source. The matching checker uses the same polynomial and bit-order conventions.

---
 rtl/prbs_gen_multi_if.sv | 23 ++
 rtl/prbs_gen_multi.sv | 92 +++++++++
 tb/tb_prbs_gen_multi.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/prbs_gen_multi_if.sv
// rtl/prbs_gen_multi_if.sv - control and data bundle for the parallel PRBS generator
interface prbs_gen_multi_if #(
  parameter int W = 128
);
  logic          en;
  logic [1:0]    mode;
  logic          seed_ld;
  logic [30:0]   seed;
  logic          inv;
  logic          err_inj;
  logic [W-1:0]  prbs_out;
  logic          prbs_valid;

  modport master (
    output en, mode, seed_ld, seed, inv, err_inj,
    input  prbs_out, prbs_valid
  );

  modport slave (
    input  en, mode, seed_ld, seed, inv, err_inj,
    output prbs_out, prbs_valid
  );
endinterface

// File: rtl/prbs_gen_multi.sv
// rtl/prbs_gen_multi.sv - W-bit-per-cycle PRBS7/15/23/31 generator with seed load,
// inversion, error injection and all-zero lock-up guard
module prbs_gen_multi #(
  parameter int         W            = 128,
  parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
  input  logic           clk160,
  input  logic           rst,
  prbs_gen_multi_if.slave bus
);

  function automatic logic [30:0] order_mask(input logic [1:0] md);
    case (md)
      2'd0:    order_mask = 31'h0000_007F;
      2'd1:    order_mask = 31'h0000_7FFF;
      2'd2:    order_mask = 31'h007F_FFFF;
      default: order_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  // Never let the all-zero state into the register; it would lock the LFSR.
  function automatic logic [30:0] guard(input logic [30:0] v, input logic [30:0] m);
    guard = ((v & m) == 31'd0) ? m : (v & m);
  endfunction

  logic [30:0]  s;
  logic [1:0]   mode_q;
  logic [30:0]  mask_q;
  logic [4:0]   hi;
  logic [4:0]   lo;
  logic [30:0]  st;
  logic         b;
  logic [W-1:0] gen;
  logic [30:0]  s_adv;
  logic [W-1:0] inj_mask;
  logic [W-1:0] out_q;
  logic         valid_q;

  assign mask_q = order_mask(mode_q);

  // hi/lo are N-1 and M-1 for the active polynomial
  always_comb begin
    case (mode_q)
      2'd0:    begin hi = 5'd6;  lo = 5'd5;  end
      2'd1:    begin hi = 5'd14; lo = 5'd13; end
      2'd2:    begin hi = 5'd22; lo = 5'd17; end
      default: begin hi = 5'd30; lo = 5'd27; end
    endcase
  end

  always_comb begin
    st  = s;
    b   = 1'b0;
    gen = '0;
    for (int i = 0; i < W; i++) begin
      b      = st[hi] ^ st[lo];
      gen[i] = b;
      st     = {st[29:0], b} & mask_q;
    end
    s_adv = st;
  end

  always_comb begin
    inj_mask    = '0;
    inj_mask[0] = bus.err_inj;
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      s       <= order_mask(DEFAULT_MODE);
      mode_q  <= DEFAULT_MODE;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.seed_ld) begin
        s <= guard(bus.seed, mask_q);
      end else if (bus.mode != mode_q) begin
        mode_q <= bus.mode;
        s      <= order_mask(bus.mode);
      end else if (bus.en) begin
        s       <= guard(s_adv, mask_q);
        out_q   <= gen ^ {W{bus.inv}} ^ inj_mask;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.prbs_out   = out_q;
  assign bus.prbs_valid = valid_q;

endmodule

// File: tb/tb_prbs_gen_multi.sv
// tb/tb_prbs_gen_multi.sv - randomized bench for prbs_gen_multi against a
// bit-history recurrence model, W=8 and W=128 instances
module tb_prbs_gen_multi;

  logic clk160 = 1'b0;
  logic rst    = 1'b1;

  prbs_gen_multi_if #(.W(8))   if8 ();
  prbs_gen_multi_if #(.W(128)) if128 ();

  prbs_gen_multi #(.W(8),   .DEFAULT_MODE(2'd0)) dut8   (.clk160(clk160), .rst(rst), .bus(if8));
  prbs_gen_multi #(.W(128), .DEFAULT_MODE(2'd0)) dut128 (.clk160(clk160), .rst(rst), .bus(if128));

  initial forever #5 clk160 = ~clk160;

  int n_chk  = 0;
  int n_pass = 0;

  bit           hist[$];
  logic [1:0]   m_mode;
  logic [255:0] m_out;
  logic         m_valid;
  int           w;
  logic [255:0] o_out;
  logic         o_valid;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int ord(input logic [1:0] md);
    case (md)
      2'd0: return 7;
      2'd1: return 15;
      2'd2: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int tap(input logic [1:0] md);
    case (md)
      2'd0: return 6;
      2'd1: return 14;
      2'd2: return 18;
      default: return 28;
    endcase
  endfunction

  // History holds past sequence bits oldest first: state bit j is the bit emitted j+1 steps ago.
  task automatic m_load(input logic [30:0] v);
    int  n;
    bit  any;
    n   = ord(m_mode);
    any = 1'b0;
    for (int j = 0; j < n; j++) if (v[j]) any = 1'b1;
    hist.delete();
    for (int j = n - 1; j >= 0; j--) hist.push_back(any ? v[j] : 1'b1);
  endtask

  function automatic bit m_next();
    int n;
    int m;
    bit nb;
    n  = ord(m_mode);
    m  = tap(m_mode);
    nb = hist[hist.size() - n] ^ hist[hist.size() - m];
    hist.push_back(nb);
    if (hist.size() > 40) void'(hist.pop_front());
    return nb;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic [1:0] md, input logic sl,
                     input logic [30:0] sd, input logic iv, input logic ei);
    rst = r;
    if8.en = e;     if8.mode = md;   if8.seed_ld = sl;   if8.seed = sd;   if8.inv = iv;   if8.err_inj = ei;
    if128.en = e;   if128.mode = md; if128.seed_ld = sl; if128.seed = sd; if128.inv = iv; if128.err_inj = ei;
    @(posedge clk160);
    #1;
    if (r) begin
      m_mode  = 2'd0;
      m_load(31'h7FFF_FFFF);
      m_out   = '0;
      m_valid = 1'b0;
    end else if (sl) begin
      m_load(sd);
      m_valid = 1'b0;
    end else if (md != m_mode) begin
      m_mode = md;
      m_load(31'h7FFF_FFFF);
      m_valid = 1'b0;
    end else if (e) begin
      m_out = '0;
      for (int i = 0; i < w; i++) m_out[i] = m_next() ^ iv;
      m_out[0] = m_out[0] ^ ei;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    o_out = '0;
    if (w == 8) begin
      o_out[7:0] = if8.prbs_out;
      o_valid    = if8.prbs_valid;
    end else begin
      o_out[127:0] = if128.prbs_out;
      o_valid      = if128.prbs_valid;
    end
    chk("valid", {255'd0, o_valid}, {255'd0, m_valid});
    chk("data", o_out, m_out);
  endtask

  logic [7:0] words[$];
  int         ones;
  logic [1:0] rmode;

  initial begin
    w = 8;
    m_mode = 2'd0;
    m_load(31'h7FFF_FFFF);
    m_out = '0;
    m_valid = 1'b0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("reset_out", o_out, 256'd0);
    chk("reset_valid", {255'd0, o_valid}, 256'd0);

    // PRBS7 basic: first word, period, ones density
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("first_word", {248'd0, o_out[7:0]}, {248'd0, 8'h40});
    words.push_back(o_out[7:0]);
    for (int k = 1; k < 254; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      words.push_back(o_out[7:0]);
    end
    for (int k = 0; k < 127; k += 21)
      chk("period127", {248'd0, words[k + 127]}, {248'd0, words[k]});
    ones = 0;
    for (int k = 0; k < 127; k++) ones += int'(words[k / 8][k % 8]);
    chk("ones_per_period", 256'(ones), 256'd64);

    // Error injection on the first word
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("err_inj_word", {248'd0, o_out[7:0]}, {248'd0, 8'h41});
    for (int k = 1; k < 6; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("after_inj", {248'd0, o_out[7:0]}, {248'd0, words[k]});
    end

    // Inversion on the first word
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 0);
    chk("inv_word", {248'd0, o_out[7:0]}, {248'd0, 8'hBF});
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("after_inv", {248'd0, o_out[7:0]}, {248'd0, words[1]});

    // Lock-up guard: zero seed behaves as all-ones
    cyc(0, 1, 0, 1, 31'd0, 0, 0);
    chk("seed0_valid", {255'd0, o_valid}, 256'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("seed0_word", {248'd0, o_out[7:0]}, {248'd0, 8'h40});

    // Randomized pause/resume, seeds, mode changes, inv and injection
    rmode = 2'd0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 79) == 0) rmode = 2'($urandom_range(0, 3));
      cyc(0, ($urandom_range(0, 3) != 0), rmode, ($urandom_range(0, 59) == 0), 31'($urandom),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
    end

    // Reset mid-stream with en held high
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("midrst_out", o_out, 256'd0);
    chk("midrst_valid", {255'd0, o_valid}, 256'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("restart_word", {248'd0, o_out[7:0]}, {248'd0, 8'h40});

    // W=128: switch PRBS7 -> PRBS31 mid-stream, then long run
    w = 128;
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 0, 0, 0, 0);
    chk("mode_sw_valid", {255'd0, o_valid}, 256'd0);
    for (int k = 0; k < 10000; k++) cyc(0, 1, 3, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
